// File: rtl/ivs_axi_rd_master_pkg.sv
// Shared AXI constants, state type and fixed AR attributes for the IVS AXI read initiator.
package ivs_axi_pkg;

    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic       AR_LOCK   = 1'b0;
    localparam logic [3:0] AR_CACHE  = 4'b0011;
    localparam logic [3:0] AR_REGION = 4'h0;
    localparam logic [3:0] AR_QOS    = 4'h0;
    localparam logic [2:0] AR_PORT   = 3'b000;
    localparam logic [7:0] AR_USER   = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic is_bad_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/ivs_axi_rd_master_if.sv
// AXI read address and read data channels between the IVS initiator and its responder.
interface ivs_axi_rd_if;
    logic         arvalid;
    logic         arready;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [5:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [3:0]   arregion;
    logic [3:0]   arqos;
    logic [2:0]   arport;
    logic [7:0]   aruser;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [127:0] rdata;
    logic         rlast;
    logic [1:0]   rresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock,
               arcache, arregion, arqos, arport, aruser, rready,
        input  arready, rvalid, rid, rdata, rlast, rresp
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock,
               arcache, arregion, arqos, arport, aruser, rready,
        output arready, rvalid, rid, rdata, rlast, rresp
    );
endinterface

// File: rtl/ivs_axi_rd_master_fifo.sv
// Synchronous FIFO for R beats; head entry is read straight from storage registers.
module ivs_sync_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ivs_axi_rd_master.sv
// IVS AXI read initiator: one INCR burst per command, R beats buffered into a FIFO stream.
// Optional macro IVS_AXI_RD_PROT_CHK_EN adds rid and beat-count protocol checks to err.
//
// state | meaning
// IDLE  | ready for a command, previous burst complete
// ADDR  | AR request presented, waiting for arready
// DATA  | collecting R beats until rlast
module ivs_axi_rd_master
    import ivs_axi_pkg::*;
#(
    parameter logic [3:0] ID_VAL     = 4'h0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic          aclk,
    input  logic          arest_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [31:0]   cmd_addr,
    input  logic [5:0]    cmd_len,
    ivs_axi_rd_if.master  axi,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [127:0]  dout_data,
    output logic          dout_last,
    output logic          done,
    output logic          err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wrap_q, wrap_d;
    logic        bad_q, bad_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic          beat_hs, beat_bad;
    logic [128:0]  fifo_rd;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    assign beat_hs = axi.rvalid && axi.rready && (state_q == ST_DATA);

    always_comb begin
        beat_bad = is_bad_resp(axi.rresp);
`ifdef IVS_AXI_RD_PROT_CHK_EN
        if (axi.rid != ID_VAL) beat_bad = 1'b1;
        if (axi.rlast && (wrap_q || cnt_q != len_q)) beat_bad = 1'b1;
        if (!axi.rlast && (wrap_q || cnt_q >= len_q)) beat_bad = 1'b1;
`endif
    end

`ifndef IVS_AXI_RD_PROT_CHK_EN
    logic prot_unused;
    assign prot_unused = ^{axi.rid, wrap_q, cnt_q};
`endif

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid)                state_d = ST_ADDR;
            ST_ADDR: if (axi.arready)              state_d = ST_DATA;
            ST_DATA: if (beat_hs && axi.rlast)     state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state_q == ST_IDLE);
        axi.arvalid  = (state_q == ST_ADDR);
        axi.rready   = (fifo_count < CW'(FIFO_DEPTH));
        axi.arid     = ID_VAL;
        axi.araddr   = addr_q;
        axi.arlen    = len_q;
        axi.arsize   = AXI_SIZE_16B;
        axi.arburst  = AXI_BURST_INCR;
        axi.arlock   = AR_LOCK;
        axi.arcache  = AR_CACHE;
        axi.arregion = AR_REGION;
        axi.arqos    = AR_QOS;
        axi.arport   = AR_PORT;
        axi.aruser   = AR_USER;
        done         = done_q;
        err          = err_q;
    end

    // Beat counter is 6 bits plus a sticky wrap flag so a 65th beat is still detectable.
    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        wrap_d = wrap_q;
        bad_d  = bad_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (state_q == ST_IDLE && cmd_valid) begin
            addr_d = {cmd_addr[31:4], 4'h0};
            len_d  = cmd_len;
            bad_d  = 1'b0;
        end
        if (state_q == ST_ADDR && axi.arready) begin
            cnt_d  = '0;
            wrap_d = 1'b0;
        end
        if (beat_hs) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'h3F) wrap_d = 1'b1;
            bad_d = bad_q | beat_bad;
            if (axi.rlast) begin
                done_d = 1'b1;
                err_d  = bad_q | beat_bad;
            end
        end
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            bad_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            bad_q  <= bad_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    ivs_sync_fifo #(
        .WIDTH (129),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (arest_n),
        .push      (beat_hs && !fifo_full),
        .push_data ({axi.rdata, axi.rlast}),
        .pop       (dout_valid && dout_ready),
        .rd_data   (fifo_rd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign dout_valid = !fifo_empty;
    assign dout_data  = fifo_rd[128:1];
    assign dout_last  = fifo_rd[0];

endmodule

// File: tb/tb_ivs_axi_rd_master.sv
// Self-checking bench for ivs_axi_rd_master: transaction-level model plus directed bursts.
module tb_ivs_axi_rd_master;

    logic         aclk = 1'b0;
    logic         arest_n = 1'b0;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic [5:0]   cmd_len;
    logic         dout_valid;
    logic         dout_ready;
    logic [127:0] dout_data;
    logic         dout_last;
    logic         done;
    logic         err;

    always #5 aclk = ~aclk;

    ivs_axi_rd_if axi_if();

    ivs_axi_rd_master #(.ID_VAL(4'h0), .FIFO_DEPTH(4)) dut (
        .aclk       (aclk),
        .arest_n    (arest_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .axi        (axi_if),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_last  (dout_last),
        .done       (done),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction-level model: what the stream, AR channel and done/err must look like.
    logic [128:0] m_q[$];
    bit           m_busy, m_ar_pend, m_acc, m_done_nx, m_err_nx;
    logic [31:0]  m_addr;
    logic [5:0]   m_len;
    int           m_idx;
    int           done_cnt = 0, pop_cnt = 0, push_cnt = 0;
    logic         last_err;
    logic [127:0] last_pop_data;
    logic         last_pop_last;
    logic [31:0]  ar_addr_seen;
    logic [5:0]   ar_len_seen;

    always @(negedge aclk) begin
        if (!arest_n) begin
            m_q.delete();
            m_busy = 0; m_ar_pend = 0; m_acc = 0; m_done_nx = 0; m_err_nx = 0;
        end else begin
            bit e;
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("arvalid", axi_if.arvalid, m_ar_pend);
            if (m_ar_pend) begin
                chk("araddr", axi_if.araddr, m_addr);
                chk("arlen", axi_if.arlen, m_len);
            end
            chk("rready", axi_if.rready, m_q.size() < 4);
            chk("dout_valid", dout_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("dout_data", dout_data, m_q[0][128:1]);
                chk("dout_last", dout_last, m_q[0][0]);
            end
            chk("done", done, m_done_nx);
            chk("err", err, m_done_nx ? m_err_nx : 1'b0);
            if (done) begin
                done_cnt++;
                last_err = err;
            end
            m_done_nx = 0;
            if (dout_valid && dout_ready && m_q.size() != 0) begin
                last_pop_data = dout_data;
                last_pop_last = dout_last;
                pop_cnt++;
                void'(m_q.pop_front());
            end
            if (axi_if.rvalid && axi_if.rready && m_busy && !m_ar_pend) begin
                e = axi_if.rresp[1];
`ifdef IVS_AXI_RD_PROT_CHK_EN
                if (axi_if.rid != 4'h0) e = 1;
                if (axi_if.rlast && m_idx != int'(m_len)) e = 1;
                if (!axi_if.rlast && m_idx >= int'(m_len)) e = 1;
`endif
                m_acc = m_acc | e;
                m_idx++;
                m_q.push_back({axi_if.rdata, axi_if.rlast});
                push_cnt++;
                if (axi_if.rlast) begin
                    m_done_nx = 1;
                    m_err_nx  = m_acc;
                    m_busy    = 0;
                end
            end
            if (m_ar_pend && axi_if.arready) begin
                m_ar_pend    = 0;
                m_idx        = 0;
                m_acc        = 0;
                ar_addr_seen = axi_if.araddr;
                ar_len_seen  = axi_if.arlen;
            end
            if (cmd_valid && !m_busy) begin
                m_busy    = 1;
                m_ar_pend = 1;
                m_addr    = cmd_addr & 32'hFFFF_FFF0;
                m_len     = cmd_len;
            end
        end
    end

    // Responder-side burst driver; abort_after >= 0 pulls reset after that many beats.
    task automatic run_burst(input logic [31:0] addr, input logic [5:0] len, input int nbeats,
                             input int bad_beat, input int ar_delay, input logic [127:0] base,
                             input int abort_after);
        int t;
        @(posedge aclk); #1;
        cmd_valid = 1; cmd_addr = addr; cmd_len = len; axi_if.arready = 0;
        t = 0;
        while (!cmd_ready && t < 200) begin @(posedge aclk); #1; t++; end
        if (t >= 200) chk("cmd_timeout", 0, 1);
        @(posedge aclk); #1;
        cmd_valid = 0;
        for (int i = 0; i < ar_delay; i++) begin
            chk("stall_arvalid", axi_if.arvalid, 1);
            chk("stall_araddr", axi_if.araddr, addr & 32'hFFFF_FFF0);
            chk("stall_arlen", axi_if.arlen, len);
            chk("stall_cmd_ready", cmd_ready, 0);
            @(posedge aclk); #1;
        end
        axi_if.arready = 1;
        @(posedge aclk); #1;
        axi_if.arready = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (i == abort_after) begin
                arest_n = 0;
                axi_if.rvalid = 0; axi_if.rlast = 0; axi_if.rresp = 2'b00;
                #1;
                chk("rst_arvalid", axi_if.arvalid, 0);
                chk("rst_dout_valid", dout_valid, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_done", done, 0);
                repeat (3) @(posedge aclk);
                #1 arest_n = 1;
                return;
            end
            axi_if.rvalid = 1;
            axi_if.rid    = 4'h0;
            axi_if.rdata  = base ^ 128'(i);
            axi_if.rlast  = (i == nbeats - 1);
            axi_if.rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
            t = 0;
            while (!axi_if.rready && t < 200) begin @(posedge aclk); #1; t++; end
            if (t >= 200) chk("rready_timeout", 0, 1);
            @(posedge aclk); #1;
        end
        axi_if.rvalid = 0; axi_if.rlast = 0; axi_if.rresp = 2'b00;
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (done_cnt == prev && t < 400) begin @(negedge aclk); t++; end
        if (t >= 400) chk("done_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_pops(input int target);
        int t = 0;
        while (pop_cnt < target && t < 400) begin @(negedge aclk); t++; end
        if (t >= 400) chk("pop_timeout", pop_cnt, target);
        #1;
    endtask

    initial begin
        int d0, p0, s0;
        cmd_valid = 0; cmd_addr = '0; cmd_len = '0; dout_ready = 1;
        axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rid = 4'h0;
        axi_if.rdata = '0; axi_if.rlast = 0; axi_if.rresp = 2'b00;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_arvalid", axi_if.arvalid, 0);
        chk("reset_araddr", axi_if.araddr, 0);
        chk("reset_arlen", axi_if.arlen, 0);
        chk("reset_rready", axi_if.rready, 1);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_dout_data", dout_data, 0);
        chk("reset_dout_last", dout_last, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        arest_n = 1;

        // Single-beat read
        d0 = done_cnt; p0 = pop_cnt;
        run_burst(32'h1000_0000, 6'd0, 1, -1, 0, {16{8'hA5}}, -1);
        wait_done(d0);
        chk("t1_err", last_err, 0);
        wait_pops(p0 + 1);
        chk("t1_data", last_pop_data, {16{8'hA5}});
        chk("t1_last", last_pop_last, 1);
        chk("t1_araddr", ar_addr_seen, 32'h1000_0000);
        chk("t1_arlen", ar_len_seen, 0);
        chk("arid", axi_if.arid, 4'h0);
        chk("arsize", axi_if.arsize, 3'b100);
        chk("arburst", axi_if.arburst, 2'b01);
        chk("arlock", axi_if.arlock, 0);
        chk("arcache", axi_if.arcache, 4'b0011);
        chk("arregion", axi_if.arregion, 0);
        chk("arqos", axi_if.arqos, 0);
        chk("arport", axi_if.arport, 3'b000);
        chk("aruser", axi_if.aruser, 8'h00);

        // Full 64-beat burst with downstream backpressure
        d0 = done_cnt; p0 = pop_cnt; s0 = push_cnt;
        fork
            run_burst(32'h2000_0100, 6'd63, 64, -1, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3200, -1);
            begin
                dout_ready = 0;
                repeat (16) @(posedge aclk);
                #1;
                chk("bp_beats", push_cnt - s0, 4);
                chk("bp_rready", axi_if.rready, 0);
                repeat (4) @(posedge aclk);
                #1 dout_ready = 1;
            end
        join
        wait_done(d0);
        chk("bp_err", last_err, 0);
        wait_pops(p0 + 64);
        chk("bp_delivered", pop_cnt - p0, 64);
        chk("bp_last", last_pop_last, 1);
        chk("bp_last_data", last_pop_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_323F);

        // AR stall with low address bits set
        d0 = done_cnt;
        run_burst(32'h2000_0007, 6'd5, 6, -1, 10, 128'h55, -1);
        wait_done(d0);
        chk("stall_err", last_err, 0);
        chk("stall_ar_seen", ar_addr_seen, 32'h2000_0000);

        // SLVERR on one beat, then a clean burst
        d0 = done_cnt; p0 = pop_cnt;
        run_burst(32'h3000_0040, 6'd3, 4, 2, 0, 128'hBEEF_0000, -1);
        wait_done(d0);
        chk("resp_err", last_err, 1);
        wait_pops(p0 + 4);
        chk("resp_delivered", pop_cnt - p0, 4);
        d0 = done_cnt;
        run_burst(32'h3000_0080, 6'd3, 4, -1, 0, 128'hCAFE_0000, -1);
        wait_done(d0);
        chk("clean_err", last_err, 0);

        // Early rlast: cmd_len=3, rlast on the second beat
        d0 = done_cnt;
        run_burst(32'h4000_0000, 6'd3, 2, -1, 0, 128'h7700, -1);
        wait_done(d0);
`ifdef IVS_AXI_RD_PROT_CHK_EN
        chk("prot_err", last_err, 1);
`else
        chk("prot_err", last_err, 0);
`endif

        // Reset after 2 of 8 beats, then a fresh single-beat command
        run_burst(32'h5000_0000, 6'd7, 8, -1, 0, 128'h9900, 2);
        d0 = done_cnt; p0 = pop_cnt;
        run_burst(32'h6000_0000, 6'd0, 1, -1, 0, 128'h1234_5678, -1);
        wait_done(d0);
        chk("post_rst_err", last_err, 0);
        wait_pops(p0 + 1);
        chk("post_rst_data", last_pop_data, 128'h1234_5678);
        chk("post_rst_araddr", ar_addr_seen, 32'h6000_0000);

        repeat (10) @(posedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ivs_axi_rd_master.md
# ivs_axi_rd_master

AXI read initiator for the IVS datapath, acting as the counterpart of the bench AXI read responder. It accepts one read command at a time (address plus beat count), issues a single INCR burst on the AR channel, and collects the R beats into a small internal FIFO. The FIFO drives a valid/ready stream to downstream IVS logic. It reports completion and response errors per burst.

## Interface
- ID_VAL, 4'h0: constant driven on arid; also the expected rid.
- FIFO_DEPTH, 4: R-beat buffer depth; power of two, minimum 2.
- aclk  in  1  clock
- arest_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_addr  in  32  byte address; bits [3:0] are ignored and forced to 0
- cmd_len  in  6  beats minus 1, range 0..63
- arvalid / arready  out / in  1 / 1  AR handshake
- arid  out  4  ID_VAL
- araddr  out  32  registered address
- arlen  out  6  registered cmd_len
- arsize  out  3  fixed 3'b100 (16 B)
- arburst  out  2  fixed 2'b01 (INCR)
- arlock  out  1  0
- arcache / arregion / arqos  out  4 each  4'b0011 / 0 / 0
- arport  out  3  3'b000
- aruser  out  8  0
- rvalid / rready  in / out  1 / 1  R handshake
- rid  in  4  read ID
- rdata  in  128  beat data
- rlast  in  1  last beat
- rresp  in  2  beat response
- dout_valid / dout_ready  out / in  1 / 1  output stream handshake
- dout_data  out  128  FIFO head data
- dout_last  out  1  FIFO head is the last beat of its burst
- done  out  1  one-cycle pulse at burst end
- err  out  1  valid only with done; 1 if any beat was bad

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: cmd_ready=1. On a cmd handshake, register the address and length, then go to ADDR.
- ADDR: arvalid=1 and the AR fields are held stable until arready. On arready, go to DATA and clear the beat counter.
- DATA: rready = (FIFO count < FIFO_DEPTH). Each R handshake pushes {rdata, rlast} into the FIFO and increments the beat counter (6 bits, plus a wrap flag).
- The burst ends on the R handshake carrying rlast. On that handshake, go to IDLE and register done and err for the next cycle.
- Bad beat: rresp is 2'b10 or 2'b11. The beat is still pushed and the error is sticky for the burst.
- FIFO pop: when dout_valid && dout_ready. Push and pop in the same cycle leave the count unchanged; a push while full is impossible because rready is 0.
- A new command may be accepted while the FIFO still drains. Its beats queue behind the earlier data.

## Timing
- Reset values: state=IDLE, cmd_ready=1, arvalid=0, araddr=0, arlen=0, rready=1, dout_valid=0, dout_data=0, dout_last=0, done=0, err=0, FIFO empty.
- Command accepted in cycle N → arvalid=1 in cycle N+1.
- R handshake in cycle M → dout_valid=1 in cycle M+1 (registered FIFO, no bypass).
- rlast handshake in cycle M → done=1 in cycle M+1 and cmd_ready=1 in cycle M+1.
- Minimum gap between bursts: 2 cycles (IDLE, then ADDR).
- Reset asserted mid-burst: all state clears immediately and FIFO contents are discarded. Outstanding responder beats are the system's responsibility.
- arvalid is never deasserted before arready; AR fields never change while arvalid=1.

## Configuration
- IVS_AXI_RD_PROT_CHK_EN defined: err is additionally set when any of the following occurs:
  - rid != ID_VAL;
  - rlast arrives with beat count != arlen;
  - beat count exceeds arlen without rlast.
  - In the overrun case, the burst still ends only at rlast.
- Undefined: only rresp contributes to err; rid and the beat count are not checked.

## Structure
- Package ivs_axi_pkg holds:
  - AXI_SIZE_16B, AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - the state enum type;
  - the fixed AR attribute constants.
- Sub-module ivs_sync_fifo (parameters WIDTH=129, DEPTH) provides count, full, empty, registered output and an async-reset pointer reset.
- The top level contains the FSM, AR registers, beat counter and error logic.

## Test plan
- Single-beat read: cmd_addr=32'h1000_0000, cmd_len=0, arready=1 immediately, one beat rdata=128'hA5.., rlast=1, rresp=0 → araddr=32'h1000_0000, arlen=0, dout_data=128'hA5.. with dout_last=1, done=1, err=0.
- Full burst with backpressure: cmd_len=63, dout_ready=0 for 20 cycles → rready drops after 4 beats, 64 beats delivered in order, the final beat has dout_last=1, no data lost.
- AR stall: arready held at 0 for 10 cycles → arvalid stays 1 with araddr/arlen stable; cmd_ready=0 throughout.
- Error response: 4-beat burst with beat 2 rresp=2'b10 → all 4 beats delivered, done=1 with err=1; the next clean burst reports err=0.
- Protocol check (macro defined): cmd_len=3 with rlast on beat 2 → err=1 and done 1 cycle after beat 2. Same case with the macro undefined → err=0.
- Reset mid-burst: arest_n=0 after 2 of 8 beats → immediately arvalid=0, dout_valid=0, cmd_ready=1; a new 1-beat command after release completes normally.
